mouse_cursor_overlay: RTL and testbench
=======================================

MOUSE_CURSOR_OVERLAY -- requirements
Module: mouse_cursor_overlay

Interface
REQ-001 SHALL have parameter COLUMNS, default 640: horizontal pixel count.
REQ-002 SHALL have parameter ROWS, default 480: vertical pixel count.
REQ-003 SHALL have parameter HALF_SIZE, default 4: cursor half-extent in pixels, range 0..15.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30: frames per blink phase, range 1..255.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port reset_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port mouse_x_position_i, input, $clog2(COLUMNS) bits: requested cursor column.
REQ-008 SHALL have port mouse_y_position_i, input, $clog2(ROWS) bits: requested cursor row.
REQ-009 SHALL have port mouse_valid_i, input, 1 bit: one-cycle strobe that captures the mouse position.
REQ-010 SHALL have port frame_start_i, input, 1 bit: one-cycle pulse at start of each frame.
REQ-011 SHALL have port mode_i, input, 2 bits: cursor shape, 0 off, 1 dot, 2 crosshair, 3 box outline.
REQ-012 SHALL have port blink_en_i, input, 1 bit: enables blinking.
REQ-013 SHALL have port pixel_x_i, input, $clog2(COLUMNS) bits: current scan column.
REQ-014 SHALL have port pixel_y_i, input, $clog2(ROWS) bits: current scan row.
REQ-015 SHALL have port cursor_draw_o, output, 1 bit: the pixel belongs to the visible cursor.
REQ-016 SHALL have port cursor_x_o, output, $clog2(COLUMNS) bits: active (frame-latched) cursor column.
REQ-017 SHALL have port cursor_y_o, output, $clog2(ROWS) bits: active (frame-latched) cursor row.

Function
REQ-018 SHALL hold a shadow position register, loaded on mouse_valid_i=1.
- x clamped to COLUMNS-1, y clamped to ROWS-1.
REQ-019 SHALL load the active position and active mode from shadow/mode_i only on frame_start_i=1 (no mid-frame tearing).
REQ-020 SHALL, when mouse_valid_i and frame_start_i coincide, load the incoming clamped position directly into both shadow and active registers.
REQ-021 SHALL compute dx=|pixel_x_i-cursor_x| and dy=|pixel_y_i-cursor_y| at width+1 bits with no wrap-around.
- Pixels beyond screen edges are never generated.
- Partial cursors at edges are simply clipped.
REQ-022 SHALL define the shape hit as follows:
- dot: dx<=HALF_SIZE and dy<=HALF_SIZE, filled square.
- crosshair: (dx==0 and dy<=HALF_SIZE) or (dy==0 and dx<=HALF_SIZE).
- box: dx<=HALF_SIZE, dy<=HALF_SIZE and (dx==HALF_SIZE or dy==HALF_SIZE).
- off: never.
- With HALF_SIZE=0, every mode except off hits only the exact cursor pixel.
REQ-023 SHALL register the hit so that cursor_draw_o reflects the pixel presented exactly 2 cycles earlier.
- Stage 1: registered dx/dy and flags.
- Stage 2: registered hit AND visible.
REQ-024 SHALL keep a frame counter 0..BLINK_FRAMES-1 that increments on frame_start_i, wraps to 0, and toggles blink_phase on wrap.
REQ-025 SHALL set visible = (blink_en_i==0) or (blink_phase==1); blink_phase=1 is the shown phase.
REQ-026 SHALL, when blink_en_i falls to 0, hold the frame counter and blink_phase at their current values, and resume counting when it rises again.
REQ-027 SHALL drive cursor_x_o/cursor_y_o from the active registers combinationally, with no added latency.

Reset
REQ-028 SHALL, while reset_ni=0, asynchronously force:
- shadow position = (COLUMNS/2, ROWS/2), clamped as in REQ-018.
- active position = (COLUMNS/2, ROWS/2), clamped as in REQ-018.
- active mode = 1 (dot).
- frame counter = 0, blink_phase = 1.
- pipeline registers = 0, cursor_draw_o = 0.
REQ-029 SHALL resume on the first clock edge after reset_ni returns to 1.
- A reset mid-frame discards pending shadow data.
- Output is 0 until the pipeline refills.

Verification
REQ-030 SHALL cover reset defaults:
- Release reset, scan (320,240) and (325,240), default parameters -> cursor_draw_o 1 for (320,240) and 0 for (325,240), each 2 cycles later; cursor_x_o=320.
REQ-031 SHALL cover tearing avoidance:
- mouse_valid_i with (100,50) mid-frame -> cursor_x_o stays 320 until next frame_start_i.
- Then 100/50 -> draw at (104,54) and not at (105,50).
REQ-032 SHALL cover shapes:
- Mode 2, cursor (100,50) -> (100,46) and (96,50) draw; (101,51) does not.
- Mode 3 -> (104,52) draws; (102,52) does not.
REQ-033 SHALL cover clamp and edge:
- mouse_valid_i with x=700, y=479 coincident with frame_start_i -> cursor_x_o=639 same next cycle.
- Pixel (635,479) draws; no spurious hit at x=0.
REQ-034 SHALL cover blink, BLINK_FRAMES=2:
- blink_en_i=1 -> cursor visible frames 0-1, hidden frames 2-3, visible frames 4-5.
- Drop blink_en_i during the hidden phase -> visible immediately.
REQ-035 SHALL cover async reset:
- Assert reset_ni mid-line between clock edges -> cursor_draw_o 0 before the next clock edge, active position back to (320,240).

Source files
------------

// File: rtl/mouse_cursor_overlay.sv
// Mouse cursor overlay: frame-latched cursor position/mode, shape hit test,
// and blink control, producing a per-pixel draw flag two cycles after the scan
// coordinate is presented.
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   mouse_x/y_position_i     requested cursor position, captured on mouse_valid_i
//   mouse_valid_i            one-cycle strobe loading the shadow position
//   frame_start_i            one-cycle pulse; latches shadow/mode_i into active state
//   mode_i                   0 off, 1 dot, 2 crosshair, 3 box outline
//   blink_en_i               enables blinking
//   pixel_x_i, pixel_y_i     current scan coordinate
//   cursor_draw_o            scan pixel (2 cycles earlier) belongs to visible cursor
//   cursor_x_o, cursor_y_o   active (frame-latched) cursor position
module mouse_cursor_overlay #(
  parameter int unsigned COLUMNS      = 640,
  parameter int unsigned ROWS         = 480,
  parameter int unsigned HALF_SIZE    = 4,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [$clog2(COLUMNS)-1:0] mouse_x_position_i,
  input  logic [$clog2(ROWS)-1:0]    mouse_y_position_i,
  input  logic                       mouse_valid_i,
  input  logic                       frame_start_i,
  input  logic [1:0]                 mode_i,
  input  logic                       blink_en_i,
  input  logic [$clog2(COLUMNS)-1:0] pixel_x_i,
  input  logic [$clog2(ROWS)-1:0]    pixel_y_i,
  output logic                       cursor_draw_o,
  output logic [$clog2(COLUMNS)-1:0] cursor_x_o,
  output logic [$clog2(ROWS)-1:0]    cursor_y_o
);

  localparam int unsigned XW     = $clog2(COLUMNS);
  localparam int unsigned YW     = $clog2(ROWS);
  localparam int unsigned CW     = 8;
  localparam int unsigned X_MAX  = COLUMNS - 1;
  localparam int unsigned Y_MAX  = ROWS - 1;
  localparam int unsigned X_RST  = (COLUMNS / 2 > X_MAX) ? X_MAX : COLUMNS / 2;
  localparam int unsigned Y_RST  = (ROWS / 2 > Y_MAX) ? Y_MAX : ROWS / 2;
  localparam int unsigned CNT_MAX = BLINK_FRAMES - 1;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_DOT   = 2'd1;
  localparam logic [1:0] MODE_CROSS = 2'd2;
  localparam logic [1:0] MODE_BOX   = 2'd3;

  logic [XW-1:0] shadow_x_q, active_x_q, clamp_x_c;
  logic [YW-1:0] shadow_y_q, active_y_q, clamp_y_c;
  logic [1:0]    active_mode_q;
  logic [CW-1:0] frame_cnt_q;
  logic          blink_phase_q;
  logic [XW:0]   dx_c, dx_q;
  logic [YW:0]   dy_c, dy_q;
  logic [1:0]    mode_s1_q;
  logic          hit_c;
  logic          visible_c;

  // Clamp incoming mouse coordinates to the visible screen.
  always_comb begin
    clamp_x_c = mouse_x_position_i;
    clamp_y_c = mouse_y_position_i;
    if (mouse_x_position_i > XW'(X_MAX)) clamp_x_c = XW'(X_MAX);
    if (mouse_y_position_i > YW'(Y_MAX)) clamp_y_c = YW'(Y_MAX);
  end

  // Shadow position follows the mouse; active state only changes at frame start.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shadow_x_q    <= XW'(X_RST);
      shadow_y_q    <= YW'(Y_RST);
      active_x_q    <= XW'(X_RST);
      active_y_q    <= YW'(Y_RST);
      active_mode_q <= MODE_DOT;
    end else begin
      if (mouse_valid_i) begin
        shadow_x_q <= clamp_x_c;
        shadow_y_q <= clamp_y_c;
      end
      if (frame_start_i) begin
        active_mode_q <= mode_i;
        // A coincident strobe bypasses the shadow so the new position is used now.
        if (mouse_valid_i) begin
          active_x_q <= clamp_x_c;
          active_y_q <= clamp_y_c;
        end else begin
          active_x_q <= shadow_x_q;
          active_y_q <= shadow_y_q;
        end
      end
    end
  end

  // Blink counter; frozen while blinking is disabled.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (frame_start_i && blink_en_i) begin
      if (frame_cnt_q >= CW'(CNT_MAX)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + CW'(1);
      end
    end
  end

  assign visible_c = !blink_en_i || blink_phase_q;

  // Absolute distances at one extra bit so the subtraction never wraps.
  always_comb begin
    if (pixel_x_i >= active_x_q) dx_c = (XW+1)'(pixel_x_i) - (XW+1)'(active_x_q);
    else                         dx_c = (XW+1)'(active_x_q) - (XW+1)'(pixel_x_i);
    if (pixel_y_i >= active_y_q) dy_c = (YW+1)'(pixel_y_i) - (YW+1)'(active_y_q);
    else                         dy_c = (YW+1)'(active_y_q) - (YW+1)'(pixel_y_i);
  end

  // Stage 1: distances and the mode they are to be judged against.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dx_q      <= '0;
      dy_q      <= '0;
      mode_s1_q <= MODE_OFF;
    end else begin
      dx_q      <= dx_c;
      dy_q      <= dy_c;
      mode_s1_q <= active_mode_q;
    end
  end

  // Shape hit test on the stage-1 distances.
  always_comb begin
    logic x_in, y_in, x_zero, y_zero, x_edge, y_edge;
    x_in   = dx_q <= (XW+1)'(HALF_SIZE);
    y_in   = dy_q <= (YW+1)'(HALF_SIZE);
    x_zero = dx_q == '0;
    y_zero = dy_q == '0;
    x_edge = dx_q == (XW+1)'(HALF_SIZE);
    y_edge = dy_q == (YW+1)'(HALF_SIZE);
    hit_c  = 1'b0;
    case (mode_s1_q)
      MODE_DOT:   hit_c = x_in && y_in;
      MODE_CROSS: hit_c = (x_zero && y_in) || (y_zero && x_in);
      MODE_BOX:   hit_c = x_in && y_in && (x_edge || y_edge);
      default:    hit_c = 1'b0;
    endcase
  end

  // Stage 2: registered draw flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cursor_draw_o <= 1'b0;
    else           cursor_draw_o <= hit_c && visible_c;
  end

  assign cursor_x_o = active_x_q;
  assign cursor_y_o = active_y_q;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Directed bench for mouse_cursor_overlay (BLINK_FRAMES=2, other parameters default).
module tb_mouse_cursor_overlay;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic [9:0] mouse_x_position_i;
  logic [8:0] mouse_y_position_i;
  logic       mouse_valid_i;
  logic       frame_start_i;
  logic [1:0] mode_i;
  logic       blink_en_i;
  logic [9:0] pixel_x_i;
  logic [8:0] pixel_y_i;
  logic       cursor_draw_o;
  logic [9:0] cursor_x_o;
  logic [8:0] cursor_y_o;

  int vectors = 0;
  int miscompares = 0;

  mouse_cursor_overlay #(
    .COLUMNS(640), .ROWS(480), .HALF_SIZE(4), .BLINK_FRAMES(2)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .mouse_x_position_i(mouse_x_position_i), .mouse_y_position_i(mouse_y_position_i),
    .mouse_valid_i(mouse_valid_i), .frame_start_i(frame_start_i),
    .mode_i(mode_i), .blink_en_i(blink_en_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
    .cursor_draw_o(cursor_draw_o), .cursor_x_o(cursor_x_o), .cursor_y_o(cursor_y_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a pixel, wait the two pipeline cycles, check the draw flag.
  task automatic scan(input string tag, input int px, input int py, input int exp_draw);
    pixel_x_i = 10'(px);
    pixel_y_i = 9'(py);
    step();
    step();
    check(tag, int'(cursor_draw_o), exp_draw);
  endtask

  task automatic frame(input int mode);
    mode_i        = 2'(mode);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0;
    mouse_x_position_i = '0; mouse_y_position_i = '0;
    mouse_valid_i = 1'b0; frame_start_i = 1'b0;
    mode_i = 2'd1; blink_en_i = 1'b0;
    pixel_x_i = '0; pixel_y_i = '0;

    // Reset defaults
    #12;
    check("rst_draw", int'(cursor_draw_o), 0);
    check("rst_x", int'(cursor_x_o), 320);
    check("rst_y", int'(cursor_y_o), 240);
    reset_ni = 1'b1;
    step();
    scan("dflt_center", 320, 240, 1);
    scan("dflt_dx5", 325, 240, 0);
    scan("dflt_corner", 316, 244, 1);
    check("dflt_x", int'(cursor_x_o), 320);

    // Tearing avoidance
    mouse_x_position_i = 10'd100; mouse_y_position_i = 9'd50;
    mouse_valid_i = 1'b1;
    step();
    mouse_valid_i = 1'b0;
    check("tear_x_hold", int'(cursor_x_o), 320);
    check("tear_y_hold", int'(cursor_y_o), 240);
    scan("tear_old_pos", 320, 240, 1);
    frame(1);
    check("tear_x_new", int'(cursor_x_o), 100);
    check("tear_y_new", int'(cursor_y_o), 50);
    scan("dot_104_54", 104, 54, 1);
    scan("dot_105_50", 105, 50, 0);

    // Shapes
    frame(2);
    scan("cross_100_46", 100, 46, 1);
    scan("cross_96_50", 96, 50, 1);
    scan("cross_101_51", 101, 51, 0);
    scan("cross_100_45", 100, 45, 0);
    frame(3);
    scan("box_104_52", 104, 52, 1);
    scan("box_102_52", 102, 52, 0);
    scan("box_96_46", 96, 46, 1);
    scan("box_center", 100, 50, 0);

    // Clamp and edge with coincident strobe
    mouse_x_position_i = 10'd700; mouse_y_position_i = 9'd479;
    mouse_valid_i = 1'b1;
    frame(1);
    mouse_valid_i = 1'b0;
    check("clamp_x", int'(cursor_x_o), 639);
    check("clamp_y", int'(cursor_y_o), 479);
    scan("edge_635_479", 635, 479, 1);
    scan("edge_639_479", 639, 479, 1);
    scan("edge_x0", 0, 479, 0);
    frame(0);
    check("shadow_x", int'(cursor_x_o), 639);
    scan("off_639_479", 639, 479, 0);
    frame(1);

    // Blink, two frames per phase
    blink_en_i = 1'b1;
    scan("blink_f0", 639, 479, 1);
    frame(1); scan("blink_f1", 639, 479, 1);
    frame(1); scan("blink_f2", 639, 479, 0);
    frame(1); scan("blink_f3", 639, 479, 0);
    frame(1); scan("blink_f4", 639, 479, 1);
    frame(1); scan("blink_f5", 639, 479, 1);
    frame(1); scan("blink_f6", 639, 479, 0);
    blink_en_i = 1'b0;
    scan("blink_off_show", 639, 479, 1);
    frame(1);
    frame(1);
    blink_en_i = 1'b1;
    scan("blink_held", 639, 479, 0);
    frame(1); scan("blink_resume1", 639, 479, 0);
    frame(1); scan("blink_resume2", 639, 479, 1);
    blink_en_i = 1'b0;

    // Async reset between edges
    mouse_x_position_i = 10'd10; mouse_y_position_i = 9'd10;
    mouse_valid_i = 1'b1;
    frame(1);
    mouse_valid_i = 1'b0;
    scan("pre_rst_draw", 10, 10, 1);
    #3;
    reset_ni = 1'b0;
    #1;
    check("arst_draw", int'(cursor_draw_o), 0);
    check("arst_x", int'(cursor_x_o), 320);
    check("arst_y", int'(cursor_y_o), 240);
    #2;
    reset_ni = 1'b1;
    step();
    scan("post_rst_old", 10, 10, 0);
    scan("post_rst_center", 320, 240, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
